// File: rtl/axis_arb_user_tcp_pkg.sv
// Shared types and widths for the user TCP TX arbiter: send request layout,
// AXIS data width and beat geometry.
package axis_arb_user_tcp_pkg;

    localparam int AXI_DATA_BITS = 512;
    localparam int BEAT_LOG_BITS = 6;
    localparam int LEN_BITS      = 16;
    localparam int BLEN_BITS     = LEN_BITS - BEAT_LOG_BITS;
    localparam int PID_BITS      = 6;
    localparam int DEST_BITS     = 4;

    typedef struct packed {
        logic [PID_BITS-1:0]  pid;
        logic [DEST_BITS-1:0] dest;
        logic [LEN_BITS-1:0]  len;
    } req_t;

    // Index width that stays at least one bit for a single-entry range.
    function automatic int clog2s(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_arb_user_tcp_rr_arb_sel.sv
// Combinational round-robin select: first set bit of valid at or after ptr,
// wrapping modulo N.
module rr_arb_sel #(
    parameter int N      = 2,
    parameter int N_BITS = 1
) (
    input  logic [N-1:0]      valid,
    input  logic [N_BITS-1:0] ptr,
    output logic [N_BITS-1:0] idx,
    output logic              any
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        idx = '0;
        any = 1'b0;
        // Scan farthest-first so the candidate nearest the pointer is written last and wins.
        for (int i = N - 1; i >= 0; i--) begin
            int j;
            j = (int'(ptr) + i) % N;
            if (valid[j]) begin
                idx = N_BITS'(j);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/meta_queue.sv
// Small synchronous FIFO for request metadata; an entry written in cycle t
// becomes visible at the output in cycle t+1.
module meta_queue
    import axis_arb_user_tcp_pkg::*;
#(
    parameter int QDEPTH = 32
) (
    input  logic aclk,
    input  logic areset,
    input  logic s_valid,
    output logic s_ready,
    input  req_t s_data,
    output logic m_valid,
    input  logic m_ready,
    output req_t m_data
);

    localparam int PTR_BITS = clog2s(QDEPTH);

    req_t                mem [QDEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [PTR_BITS:0]   count;
    logic                push;
    logic                pop;

    assign s_ready = (count < (PTR_BITS+1)'(QDEPTH));
    assign m_valid = (count != '0);
    assign m_data  = mem[rd_ptr];
    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;

    function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
        return (p == PTR_BITS'(QDEPTH - 1)) ? '0 : p + PTR_BITS'(1);
    endfunction

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + (PTR_BITS+1)'(push) - (PTR_BITS+1)'(pop);
        end
    end

    // NOTE: storage is not reset; emptiness is tracked by count alone, so stale entries are never read.
    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

endmodule

// File: rtl/axis_arb_user_tcp.sv
// Merges N_SRCS user AXIS send streams into one TCP TX stream, granting requests
// round-robin. Define AXIS_ARB_TLAST_GEN_EN to regenerate tlast from the beat counter.
module axis_arb_user_tcp
    import axis_arb_user_tcp_pkg::*;
#(
    parameter int N_SRCS = 2,
    parameter int QDEPTH = 32
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [N_SRCS-1:0]          s_rq_valid,
    output logic [N_SRCS-1:0]          s_rq_ready,
    input  req_t                       s_rq_data [N_SRCS],
    output logic                       m_rq_valid,
    input  logic                       m_rq_ready,
    output req_t                       m_rq_data,
    input  logic [N_SRCS-1:0]          s_axis_tvalid,
    output logic [N_SRCS-1:0]          s_axis_tready,
    input  logic [AXI_DATA_BITS-1:0]   s_axis_tdata [N_SRCS],
    input  logic [AXI_DATA_BITS/8-1:0] s_axis_tkeep [N_SRCS],
    input  logic [N_SRCS-1:0]          s_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [AXI_DATA_BITS-1:0]   m_axis_tdata,
    output logic [AXI_DATA_BITS/8-1:0] m_axis_tkeep,
    output logic                       m_axis_tlast,
    output logic [PID_BITS-1:0]        m_axis_tid
);

    localparam int N_SRCS_BITS = clog2s(N_SRCS);

    typedef enum logic {ST_IDLE, ST_MUX} state_t;

    state_t                 state_c;
    logic [N_SRCS_BITS-1:0] src_c, rr_c, winner, rr_next;
    logic [BLEN_BITS-1:0]   cnt_c, cnt_init;
    logic [PID_BITS-1:0]    pid_c;
    logic [LEN_BITS-1:0]    len_m1;
    logic                   any_valid, q_ready, hs, tr_done, grant;
    req_t                   win_req, q_data;

    rr_arb_sel #(.N(N_SRCS), .N_BITS(N_SRCS_BITS)) u_sel (
        .valid (s_rq_valid),
        .ptr   (rr_c),
        .idx   (winner),
        .any   (any_valid)
    );

    meta_queue #(.QDEPTH(QDEPTH)) u_queue (
        .aclk    (aclk),
        .areset  (areset),
        .s_valid (grant),
        .s_ready (q_ready),
        .s_data  (q_data),
        .m_valid (m_rq_valid),
        .m_ready (m_rq_ready),
        .m_data  (m_rq_data)
    );

    always_comb begin
        hs       = (state_c == ST_MUX) & m_axis_tvalid & m_axis_tready;
        tr_done  = hs & (cnt_c == '0);
        win_req  = s_rq_data[winner];
        len_m1   = win_req.len - LEN_BITS'(1);
        cnt_init = BLEN_BITS'(len_m1 >> BEAT_LOG_BITS);
        rr_next  = (winner == N_SRCS_BITS'(N_SRCS - 1)) ? '0 : winner + N_SRCS_BITS'(1);
        q_data      = win_req;
        q_data.dest = DEST_BITS'(winner);
        grant = ~areset & any_valid & q_ready & ((state_c == ST_IDLE) | tr_done);
        s_rq_ready = '0;
        if (grant) s_rq_ready[winner] = 1'b1;
    end

    always_comb begin
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        m_axis_tdata  = s_axis_tdata[src_c];
        m_axis_tkeep  = s_axis_tkeep[src_c];
        m_axis_tid    = pid_c;
`ifdef AXIS_ARB_TLAST_GEN_EN
        m_axis_tlast  = (state_c == ST_MUX) & (cnt_c == '0);
`else
        m_axis_tlast  = s_axis_tlast[src_c];
`endif
        if (state_c == ST_MUX) begin
            m_axis_tvalid        = s_axis_tvalid[src_c];
            s_axis_tready[src_c] = m_axis_tready;
        end
    end

    // A grant on the last beat overrides the return to idle, giving back-to-back transfers.
    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (areset) begin
            state_c <= ST_IDLE;
            rr_c    <= '0;
        end else begin
            if (hs && cnt_c != '0) cnt_c <= cnt_c - BLEN_BITS'(1);
            if (tr_done) state_c <= ST_IDLE;
            if (grant) begin
                src_c   <= winner;
                pid_c   <= win_req.pid;
                cnt_c   <= cnt_init;
                rr_c    <= rr_next;
                state_c <= (win_req.len == '0) ? ST_IDLE : ST_MUX;
            end
        end
    end

endmodule

// File: tb/tb_axis_arb_user_tcp.sv
// Directed bench for axis_arb_user_tcp with four sources and a two-entry request queue.
module tb_axis_arb_user_tcp;
    import axis_arb_user_tcp_pkg::*;

    localparam int NS = 4;

    logic                       aclk = 1'b0;
    logic                       areset;
    logic [NS-1:0]              s_rq_valid;
    logic [NS-1:0]              s_rq_ready;
    req_t                       s_rq_data [NS];
    logic                       m_rq_valid;
    logic                       m_rq_ready;
    req_t                       m_rq_data;
    logic [NS-1:0]              s_axis_tvalid;
    logic [NS-1:0]              s_axis_tready;
    logic [AXI_DATA_BITS-1:0]   s_axis_tdata [NS];
    logic [AXI_DATA_BITS/8-1:0] s_axis_tkeep [NS];
    logic [NS-1:0]              s_axis_tlast;
    logic                       m_axis_tvalid;
    logic                       m_axis_tready;
    logic [AXI_DATA_BITS-1:0]   m_axis_tdata;
    logic [AXI_DATA_BITS/8-1:0] m_axis_tkeep;
    logic                       m_axis_tlast;
    logic [PID_BITS-1:0]        m_axis_tid;

    int errors = 0;
    int checks = 0;

`ifdef AXIS_ARB_TLAST_GEN_EN
    localparam logic EXP_FINAL_LAST = 1'b1;
`else
    localparam logic EXP_FINAL_LAST = 1'b0;
`endif

    axis_arb_user_tcp #(.N_SRCS(NS), .QDEPTH(2)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_rq_valid    (s_rq_valid),
        .s_rq_ready    (s_rq_ready),
        .s_rq_data     (s_rq_data),
        .m_rq_valid    (m_rq_valid),
        .m_rq_ready    (m_rq_ready),
        .m_rq_data     (m_rq_data),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    function automatic req_t mk_req(input int pid, input int len);
        req_t r;
        r.pid  = PID_BITS'(pid);
        r.dest = DEST_BITS'(7);
        r.len  = LEN_BITS'(len);
        return r;
    endfunction

    initial begin
        areset        = 1'b1;
        s_rq_valid    = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        m_rq_ready    = 1'b1;
        m_axis_tready = 1'b1;
        for (int i = 0; i < NS; i++) begin
            s_rq_data[i]    = mk_req(0, 64);
            s_axis_tdata[i] = AXI_DATA_BITS'(i + 1);
            s_axis_tkeep[i] = '1;
        end
        repeat (2) @(posedge aclk);
        #1;
        check("rst_m_rq_valid", m_rq_valid, 0);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_s_rq_ready", s_rq_ready, 0);
        areset = 1'b0;

        // Single source 0, pid 3, 128 bytes -> two beats.
        step();
        s_rq_valid = 4'b0001;
        s_rq_data[0] = mk_req(3, 128);
        s_axis_tvalid = 4'b0001;
        s_axis_tdata[0] = 'hA0;
        #1;
        check("a_rq_ready", s_rq_ready, 4'b0001);
        check("a_tvalid_idle", m_axis_tvalid, 0);
        step();
        s_rq_valid = '0;
        #1;
        check("b_m_rq_valid", m_rq_valid, 1);
        check("b_m_rq_dest", m_rq_data.dest, 0);
        check("b_m_rq_pid", m_rq_data.pid, 3);
        check("b_m_rq_len", m_rq_data.len, 128);
        check("b_tvalid", m_axis_tvalid, 1);
        check("b_tid", m_axis_tid, 3);
        check("b_tdata", m_axis_tdata, 'hA0);
        check("b_tkeep", m_axis_tkeep, {64{1'b1}});
        check("b_s_tready", s_axis_tready, 4'b0001);
        step();
        s_axis_tdata[0] = 'hA1;
        s_axis_tlast = 4'b0001;
        #1;
        check("c_m_rq_valid", m_rq_valid, 0);
        check("c_tvalid", m_axis_tvalid, 1);
        check("c_tdata", m_axis_tdata, 'hA1);
        check("c_tlast", m_axis_tlast, 1);

        // Two zero-length requests; rr pointer now at 1.
        step();
        s_axis_tlast = '0;
        s_axis_tvalid = '0;
        s_rq_valid = 4'b0011;
        s_rq_data[0] = mk_req(1, 0);
        s_rq_data[1] = mk_req(2, 0);
        #1;
        check("d_tvalid", m_axis_tvalid, 0);
        check("d_s_tready", s_axis_tready, 0);
        check("d_rq_ready", s_rq_ready, 4'b0010);
        step();
        s_rq_valid = 4'b0001;
        #1;
        check("e_rq_ready", s_rq_ready, 4'b0001);
        check("e_m_rq_valid", m_rq_valid, 1);
        check("e_m_rq_dest", m_rq_data.dest, 1);
        check("e_m_rq_len", m_rq_data.len, 0);
        check("e_tvalid", m_axis_tvalid, 0);
        step();
        s_rq_valid = '0;
        #1;
        check("f_m_rq_dest", m_rq_data.dest, 0);
        check("f_m_rq_pid", m_rq_data.pid, 1);
        check("f_tvalid", m_axis_tvalid, 0);

        // Continuous single-beat requests from 0,1,2: strict rotation starting at 1.
        step();
        for (int i = 0; i < 3; i++) begin
            s_rq_data[i] = mk_req(10 + i, 64);
            s_axis_tdata[i] = AXI_DATA_BITS'(i + 1);
        end
        s_axis_tvalid = 4'b0111;
        s_rq_valid = 4'b0111;
        #1;
        check("g_rq_ready", s_rq_ready, 4'b0010);
        step();
        check("h_rq_ready", s_rq_ready, 4'b0100);
        check("h_tvalid", m_axis_tvalid, 1);
        check("h_tdata", m_axis_tdata, 2);
        check("h_tid", m_axis_tid, 11);
        check("h_m_rq_dest", m_rq_data.dest, 1);
        step();
        check("i_rq_ready", s_rq_ready, 4'b0001);
        check("i_tdata", m_axis_tdata, 3);
        check("i_tid", m_axis_tid, 12);
        check("i_m_rq_dest", m_rq_data.dest, 2);
        step();
        check("j_rq_ready", s_rq_ready, 4'b0010);
        check("j_tdata", m_axis_tdata, 1);
        check("j_tid", m_axis_tid, 10);
        check("j_m_rq_dest", m_rq_data.dest, 0);
        step();
        s_rq_valid = '0;
        #1;
        check("k_rq_ready", s_rq_ready, 0);
        check("k_tdata", m_axis_tdata, 2);
        check("k_m_rq_dest", m_rq_data.dest, 1);
        step();
        s_axis_tvalid = '0;
        #1;
        check("l_tvalid", m_axis_tvalid, 0);

        // Four-beat transfer from source 3 with a one-cycle sink stall.
        step();
        s_rq_valid = 4'b1000;
        s_rq_data[3] = mk_req(5, 256);
        s_axis_tvalid = 4'b1000;
        s_axis_tdata[3] = 'h100;
        #1;
        check("m_rq_ready", s_rq_ready, 4'b1000);
        step();
        s_rq_valid = '0;
        #1;
        check("n_tvalid", m_axis_tvalid, 1);
        check("n_tdata", m_axis_tdata, 'h100);
        check("n_tid", m_axis_tid, 5);
        check("n_m_rq_dest", m_rq_data.dest, 3);
        step();
        s_axis_tdata[3] = 'h101;
        m_axis_tready = 1'b0;
        #1;
        check("o_tvalid", m_axis_tvalid, 1);
        check("o_s_tready_stall", s_axis_tready, 0);
        step();
        m_axis_tready = 1'b1;
        #1;
        check("p_tdata", m_axis_tdata, 'h101);
        check("p_s_tready", s_axis_tready, 4'b1000);
        step();
        s_axis_tdata[3] = 'h102;
        #1;
        check("q_tdata", m_axis_tdata, 'h102);
        check("q_tlast", m_axis_tlast, 0);
        step();
        s_axis_tdata[3] = 'h103;
        #1;
        check("r_tdata", m_axis_tdata, 'h103);
        check("r_tvalid", m_axis_tvalid, 1);
        check("r_tlast_final", m_axis_tlast, EXP_FINAL_LAST);
        step();
        check("s_tvalid_after", m_axis_tvalid, 0);

        // Two-entry queue with m_rq stalled: third request waits for space.
        step();
        m_rq_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_rq_data[i] = mk_req(20 + i, 64);
            s_axis_tdata[i] = AXI_DATA_BITS'(i + 1);
        end
        s_axis_tvalid = 4'b0111;
        s_rq_valid = 4'b0111;
        #1;
        check("t_rq_ready", s_rq_ready, 4'b0001);
        step();
        check("u_rq_ready", s_rq_ready, 4'b0010);
        check("u_m_rq_valid", m_rq_valid, 1);
        check("u_m_rq_dest", m_rq_data.dest, 0);
        check("u_tdata", m_axis_tdata, 1);
        step();
        check("v_rq_ready_full", s_rq_ready, 0);
        check("v_tvalid", m_axis_tvalid, 1);
        check("v_tdata", m_axis_tdata, 2);
        check("v_m_rq_dest", m_rq_data.dest, 0);
        step();
        check("w_rq_ready_full", s_rq_ready, 0);
        check("w_tvalid", m_axis_tvalid, 0);
        step();
        m_rq_ready = 1'b1;
        #1;
        check("x_rq_ready", s_rq_ready, 0);
        check("x_m_rq_dest", m_rq_data.dest, 0);
        step();
        check("y_rq_ready", s_rq_ready, 4'b0100);
        check("y_m_rq_dest", m_rq_data.dest, 1);
        step();
        s_rq_valid = '0;
        #1;
        check("z_m_rq_dest", m_rq_data.dest, 2);
        check("z_tvalid", m_axis_tvalid, 1);
        check("z_tdata", m_axis_tdata, 3);
        step();
        s_axis_tvalid = '0;
        #1;
        check("z2_tvalid", m_axis_tvalid, 0);
        check("z2_m_rq_valid", m_rq_valid, 0);

        // Reset during beat 2 of a four-beat transfer.
        step();
        m_rq_ready = 1'b0;
        s_rq_valid = 4'b1000;
        s_rq_data[3] = mk_req(6, 256);
        s_axis_tvalid = 4'b1000;
        s_axis_tdata[3] = 'h200;
        #1;
        check("rs_rq_ready", s_rq_ready, 4'b1000);
        step();
        s_rq_valid = '0;
        #1;
        check("rs_beat1", m_axis_tdata, 'h200);
        check("rs_m_rq_valid", m_rq_valid, 1);
        step();
        s_axis_tdata[3] = 'h201;
        areset = 1'b1;
        step();
        areset = 1'b0;
        #1;
        check("rs_tvalid_after", m_axis_tvalid, 0);
        check("rs_s_tready_after", s_axis_tready, 0);
        check("rs_m_rq_flushed", m_rq_valid, 0);
        step();
        s_rq_valid = 4'b1001;
        s_rq_data[0] = mk_req(7, 64);
        #1;
        check("rs_regrant", s_rq_ready, 4'b0001);
        step();
        s_rq_valid = '0;
        s_axis_tvalid = '0;
        m_rq_ready = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_arb_user_tcp.md
Name: axis_arb_user_tcp

Overview:
- TX-side counterpart of the per-request user TCP demux.
- Merges N_SRCS user AXIS send streams into one network-facing AXIS stream.
- Each source posts a send request (req_t); the block grants sources round-robin, forwards the request (dest rewritten to the source index) through an output meta queue, then passes exactly the requested number of beats from the granted source.
- Sits between the user vFPGA send ports and the TCP TX path.

Parameters:
- N_SRCS, 2, number of user source streams (≥1; N_SRCS_BITS = clog2s(N_SRCS)).
- QDEPTH, 32, depth of output request meta queue.

Ports:
- aclk  in  1  single clock for all logic.
- areset  in  1  reset, synchronous, active-high; one clock, no other reset.
- s_rq[N_SRCS]  in (metaIntf.s, req_t)  per-source send request: valid/ready/data {pid, len, dest, ...}.
- m_rq  out (metaIntf.m, req_t)  granted request, data.dest = granted source index.
- s_axis[N_SRCS]  in (AXI4S.s)  per-source data: tvalid/tready/tdata[AXI_DATA_BITS]/tkeep/tlast.
- m_axis  out (AXI4S.m)  merged data; tid[PID_BITS] = pid of the granted request.

Behaviour:
- FSM states: ST_IDLE, ST_MUX. Registers: grant index src_C, beat counter cnt_C[BLEN_BITS], pid_C, round-robin pointer rr_C[N_SRCS_BITS].
- Reset: state ST_IDLE, rr_C = 0, all s_rq.ready = 0, all s_axis.tready = 0, m_axis.tvalid = 0, m_rq.valid = 0 (queue empty). Other registers are don't-care.
- Arbitration runs when in ST_IDLE, or in ST_MUX on the last-beat handshake (tr_done), and only if the queue input is ready.
  - Winner: first valid s_rq scanning rr_C, rr_C+1, … modulo N_SRCS.
  - Same cycle: winner's s_rq.ready = 1; queue input valid = 1 with data = winner request and dest = winner index.
  - Registers load: src_C = winner, pid_C = pid, cnt_C = (len-1) >> BEAT_LOG_BITS, rr_C = winner+1 (wrap to 0 at N_SRCS).
  - Exactly one s_rq.ready is high per cycle.
- len == 0: request is consumed and forwarded, with no data phase. FSM goes to (or stays in) ST_IDLE; rr_C advances.
- ST_MUX datapath (combinational):
  - m_axis.tvalid = s_axis[src_C].tvalid; s_axis[src_C].tready = m_axis.tready; all other s_axis.tready = 0.
  - tdata, tkeep, tlast come from src_C; tid = pid_C.
  - tvalid = 0 and every tready = 0 in ST_IDLE.
- Counting: each handshake with cnt_C ≠ 0 decrements cnt_C.
  - tr_done = (cnt_C == 0) & handshake.
  - On tr_done: re-arbitrate the same cycle. Grant → stay ST_MUX (back-to-back, no bubble); no grant → ST_IDLE.
- Source tlast is not used for framing; the beat count is authoritative.
- m_rq latency: a grant in cycle t is visible at m_rq no earlier than t+1 (meta_queue). A full queue blocks all grants; data of the current transfer continues unaffected.
- Simultaneous requests from all sources under continuous grants: service order is strict rotation; no source waits more than N_SRCS-1 grants.
- Reset asserted mid-transfer: the transfer is abandoned, queue flushed, state ST_IDLE next cycle. Partial packets on m_axis are not completed.

Optional Feature:
- Macro AXIS_ARB_TLAST_GEN_EN.
- Defined: m_axis.tlast = (cnt_C == 0) in ST_MUX, regenerated from the counter; source tlast is ignored.
- Undefined: m_axis.tlast passes the granted source's tlast unchanged.

Decomposition:
- lynxTypes supplies req_t, AXI_DATA_BITS, BLEN_BITS, PID_BITS, BEAT_LOG_BITS, clog2s; no new package types.
- Local typedef state_t only.
- One natural sub-module, rr_arb_sel: combinational round-robin select (valid vector + pointer → winner index + any-valid).
- Output queue reuses meta_queue.

Test Plan:
- Single source 0 requests pid=3, len=128 (64B beats): grant → m_rq.dest=0; exactly 2 beats on m_axis with tid=3; FSM back to ST_IDLE; rr_C=1.
- Sources 0,1,2 (N_SRCS=4) request len=64 simultaneously, continuously: grant order 0,1,2,0,…; 1 beat each; no idle cycle between transfers.
- m_axis.tready toggling 1-0-1 during a len=256 transfer: 4 beats delivered in order; cnt_C holds while stalled; no duplicated or lost beats.
- Queue full (QDEPTH=2, m_rq.ready=0, three len=64 requests): two grants, third s_rq.ready stays 0 until m_rq.ready=1.
- len=0 request from source 1: m_rq issued with dest=1; m_axis.tvalid never asserts; next request granted the following cycle.
- areset during beat 2 of a 4-beat transfer: next cycle ST_IDLE, all tready=0, m_rq.valid=0. With AXIS_ARB_TLAST_GEN_EN, a source driving tlast=0 still yields m_axis.tlast=1 on the final beat.
